// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the shift datapath, used by decode, the ALU and the
// execute-stage shift pipe.
//   DATA_W        operand/result width of the Shifter core
//   AMT_W         shift-amount width
//   shift_mode_e  shift operation encoding carried on the 2-bit mode field
// -----------------------------------------------------------------------------
package shift_pkg;

    localparam int DATA_W = 16;
    localparam int AMT_W  = 4;

    typedef enum logic [1:0] {
        SHIFT_SLL  = 2'b00,   // logical left, zero fill
        SHIFT_SRA  = 2'b01,   // arithmetic right, sign fill
        SHIFT_ROR  = 2'b10,   // rotate right
        SHIFT_RSVD = 2'b11    // reserved encoding, passed through and flagged
    } shift_mode_e;

    // Only real shift operations write the Z flag; the reserved encoding
    // produces a passthrough value that must not disturb it.
    function automatic logic mode_writes_flag(input shift_mode_e mode);
        return mode != SHIFT_RSVD;
    endfunction

endpackage : shift_pkg

// File: rtl/shift_ex_stage_shifter.sv
// -----------------------------------------------------------------------------
// shift_ex_stage_shifter
// Combinational Shifter core (the team's existing block, port names kept).
//   Shift_In   in   DATA_W  operand
//   Shift_Val  in   AMT_W   shift amount 0..DATA_W-1
//   Mode       in   2       shift_mode_e encoding
//   Shift_Out  out  DATA_W  result; amount 0 returns Shift_In in every mode,
//                           the reserved mode returns Shift_In unchanged
// -----------------------------------------------------------------------------
module shift_ex_stage_shifter
    import shift_pkg::*;
(
    input  logic [DATA_W-1:0] Shift_In,
    input  logic [AMT_W-1:0]  Shift_Val,
    input  logic [1:0]        Mode,
    output logic [DATA_W-1:0] Shift_Out
);

    // Left-shift distance for the wrapped-around part of a rotate. With an
    // amount of 0 this is DATA_W, which shifts every bit out and leaves the
    // rotate equal to the plain operand.
    logic [AMT_W:0] rot_back;

    assign rot_back = (AMT_W + 1)'(DATA_W) - {1'b0, Shift_Val};

    always_comb begin
        // NOTE: every output of a combinational block gets a value before the
        // case, so no path through it can leave a latch behind.
        Shift_Out = Shift_In;
        case (shift_mode_e'(Mode))
            SHIFT_SLL:  Shift_Out = Shift_In << Shift_Val;
            SHIFT_SRA:  Shift_Out = $unsigned($signed(Shift_In) >>> Shift_Val);
            SHIFT_ROR:  Shift_Out = (Shift_In >> Shift_Val) | (Shift_In << rot_back);
            default:    Shift_Out = Shift_In;
        endcase
    end

endmodule : shift_ex_stage_shifter

// File: rtl/shift_ex_stage.sv
// -----------------------------------------------------------------------------
// shift_ex_stage
// Execute-stage shift pipe: takes shift micro-ops from decode on a valid/ready
// handshake, computes them with the Shifter core and holds the result in a
// single output register toward writeback. Also owns the Z flag for shift
// instructions and a counter of accepted, non-flushed ops.
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   in_valid    decode presents an op
//   in_ready    stage can accept this cycle (!out_valid || out_ready)
//   in_mode     shift_mode_e encoding
//   in_data     source operand
//   in_amt      shift amount
//   in_dst      destination register index
//   flush       squash the held op and any incoming op
//   out_valid   registered result valid
//   out_ready   writeback accepts the result
//   out_result  registered result
//   out_dst     registered destination index
//   out_err     registered op used the reserved mode
//   flag_z      Z flag, written by accepted SLL/SRA/ROR ops
//   op_count    accepted, non-flushed ops, wraps
// DATA_W is tied to the Shifter width; other values are not supported.
// -----------------------------------------------------------------------------
module shift_ex_stage
    import shift_pkg::*;
#(
    parameter int DATA_W = shift_pkg::DATA_W,
    parameter int AMT_W  = shift_pkg::AMT_W,
    parameter int DST_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_mode,
    input  logic [DATA_W-1:0] in_data,
    input  logic [AMT_W-1:0]  in_amt,
    input  logic [DST_W-1:0]  in_dst,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [DST_W-1:0]  out_dst,
    output logic              out_err,
    output logic              flag_z,
    output logic [CNT_W-1:0]  op_count
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_e;

    stage_state_e      state_q;
    stage_state_e      state_d;
    shift_mode_e       mode;
    logic              accept;
    logic [DATA_W-1:0] shift_res;

    assign mode = shift_mode_e'(in_mode);

    // The Shifter sees the raw decode inputs every cycle; its result is only
    // captured on accept, so garbage on idle cycles never reaches state.
    shift_ex_stage_shifter u_shifter (
        .Shift_In  (in_data),
        .Shift_Val (in_amt),
        .Mode      (in_mode),
        .Shift_Out (shift_res)
    );

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign out_valid = (state_q == ST_FULL);

    // Ready depends only on the output side; flush blocks the accept, not the
    // ready, so decode sees a stable ready for the whole cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // ------------------------------------------------------------------
    // Occupancy FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                // Flush wins over both a new accept and a stalled hold.
                if (flush) begin
                    state_d = ST_EMPTY;
                end else if (accept) begin
                    state_d = ST_FULL;
                end else if (out_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, whatever order the blocks evaluate in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    // NOTE: the result fields are reset as well, because writeback and debug
    // observe them as defined zeros straight out of reset.
    // They load only on accept: a stall holds them, and a drain or flush
    // leaves the last value behind as a don't-care under out_valid=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_result <= '0;
            out_dst    <= '0;
            out_err    <= 1'b0;
        end else if (accept) begin
            out_result <= shift_res;
            out_dst    <= in_dst;
            out_err    <= (mode == SHIFT_RSVD);
        end
    end

    // ------------------------------------------------------------------
    // Z flag: written at the accept edge by real shifts only, held otherwise
    // (stalls, drains, flushes and reserved-mode ops leave it alone).
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_z <= 1'b0;
        end else if (accept && mode_writes_flag(mode)) begin
            flag_z <= (shift_res == '0);
        end
    end

    // ------------------------------------------------------------------
    // Retired-op counter: every accepted op counts, reserved mode included;
    // a flushed incoming op is never accepted so it is not counted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= '0;
        end else if (accept) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

endmodule : shift_ex_stage

// File: doc/shift_ex_stage.md
Name: shift_ex_stage

Overview:
Execute-stage shift pipe. It accepts shift micro-ops from decode over a valid/ready handshake and computes them with the team's combinational Shifter core. The result is registered in a single output stage with valid/ready toward writeback. It also owns the Z flag update for shift instructions and a retired-op counter. It sits between the ID/EX boundary and the EX/MEM writeback path.

Parameters:
DATA_W, 16, operand/result width (fixed to Shifter width; other values unsupported)
AMT_W, 4, shift-amount width
DST_W, 4, destination register index width
CNT_W, 16, width of retired-op counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  decode presents a shift op
in_ready  out  1  stage can accept this cycle
in_mode  in  2  00 SLL, 01 SRA, 10 ROR, 11 reserved
in_data  in  DATA_W  source operand
in_amt  in  AMT_W  shift amount 0..15
in_dst  in  DST_W  destination register index
flush  in  1  squash held and incoming op (branch mispredict)
out_valid  out  1  registered result valid
out_ready  in  1  writeback accepts result
out_result  out  DATA_W  registered shift result
out_dst  out  DST_W  registered destination index
out_err  out  1  registered op had reserved mode
flag_z  out  1  Z flag, updated by completed shift ops
op_count  out  CNT_W  count of accepted, non-flushed ops

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_result=0, out_dst=0, out_err=0, flag_z=0, op_count=0.
- in_ready = !out_valid || out_ready (combinational). It does not depend on in_valid or flush.
- Accept = in_valid && in_ready && !flush. On accept, at the next edge:
  - out_valid=1.
  - out_result = Shifter(in_data, in_amt, in_mode).
  - out_dst = in_dst.
  - op_count increments by 1 and wraps from all-ones to 0.
- Latency: 1 cycle from accept to out_valid. Full throughput is 1 op/cycle while out_ready=1.
- Shifter semantics:
  - SLL: zero fill.
  - SRA: sign fill from bit 15.
  - ROR: rotate right.
  - Amount 0: result equals in_data in all modes.
- Reserved mode 11:
  - Op is accepted.
  - out_result = in_data (passthrough) and out_err=1 for that result.
  - flag_z is not updated.
  - op_count still increments.
- flag_z updates at the accept edge to (result == 0) for modes 00/01/10. It holds at all other times, including across backpressure and flush.
- Hold: if out_valid && !out_ready, all out_* registers hold and in_ready=0.
- Drain: if out_valid && out_ready && no accept, out_valid goes to 0 next edge. out_result/out_dst hold their last value (don't-care).
- Flush: at the next edge out_valid=0 and the incoming op is dropped. flag_z and op_count are unchanged. Flush has priority over a simultaneous accept or hold.
- State machine: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY→FULL on accept.
  - FULL→FULL on accept, or on hold.
  - FULL→EMPTY on drain without accept, or on flush.
  - Any→EMPTY on rst.
- in_mode, in_data and in_amt are sampled only on accept. X on unaccepted cycles must not propagate.

Decomposition:
- Shared package shift_pkg:
  - mode enum: SHIFT_SLL=2'b00, SHIFT_SRA=2'b01, SHIFT_ROR=2'b10, SHIFT_RSVD=2'b11.
  - DATA_W/AMT_W localparams.
  - Shared with decode and the ALU.
- One sub-module: the existing combinational Shifter (ports Shift_In, Shift_Val, Mode, Shift_Out), instantiated once and fed directly from in_data/in_amt/in_mode.
- Everything else (output register, state, flag, counter) is flat in shift_ex_stage.

Test Plan:
- Basic SLL and Z: SLL in_data=0x0001 amt=4, out_ready=1 → next cycle out_valid=1, out_result=0x0010, flag_z=0, op_count=1. Then SLL 0x8000 amt=1 → out_result=0x0000, flag_z=1.
- SRA, ROR and amount 0:
  - SRA 0x8000 amt=15 → 0xFFFF.
  - ROR 0x0001 amt=1 → 0x8000.
  - ROR 0xA5C3 amt=0 → 0xA5C3.
  - Back-to-back in consecutive cycles, results in consecutive cycles.
- Backpressure: out_ready=0 after SRA 0x4000 amt=2 → out_result=0x1000 held. in_ready=0 while a second op is presented and not accepted. Raise out_ready → second result appears the following cycle, op_count=2.
- Reserved mode: mode=11 in_data=0x1234 after flag_z=1 → out_result=0x1234, out_err=1, flag_z stays 1, op_count increments.
- Flush: flush=1 coincident with in_valid (SLL 0x0000 amt=0) while FULL → next cycle out_valid=0, flag_z and op_count unchanged.
- Reset mid-operation: assert rst asynchronously while FULL with out_ready=0 → out_valid, flag_z and op_count go to 0 immediately, before the next edge. The first op after release completes normally.
